// File: rtl/flit_rx_queue_pkg.sv
// Shared types for the flit receive queue: flit layout, flit kinds, FSM states.
package flit_rx_queue_pkg;

    localparam int FLIT_WIDTH     = 32;
    localparam int CHECKSUM_WIDTH = 8;

    typedef enum logic [1:0] {
        HEAD = 2'b00,
        BODY = 2'b01,
        TAIL = 2'b10,
        NOPE = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e  flit_type;
        logic [5:0]  src_id;
        logic [23:0] payload;
    } flit_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } rx_state_e;

    // Checksum contribution of a flit: the low byte of its payload.
    function automatic logic [CHECKSUM_WIDTH-1:0] flit_csum(input flit_t f);
        return f.payload[CHECKSUM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/flit_rx_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguishable when the address bits coincide.
module flit_rx_queue_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer by one when its side of the FIFO moves.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/flit_rx_queue.sv
// Router input queue: framing check, per-packet XOR checksum, drop counter,
// and an FWFT buffer of well-framed flits tagged with a tail checksum-error bit.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | between packets; only a HEAD is acceptable
//   ST_PKT  | inside a packet; BODY/TAIL extend it, HEAD restarts
module flit_rx_queue
    import flit_rx_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  flit_t                in_flit,
    input  logic                 in_valid,
    output logic                 in_ready,
    output flit_t                out_flit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_crc_err,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 full,
    output logic                 empty
);

    rx_state_e                 state_q, state_d;
    logic [CHECKSUM_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]      drop_q, drop_d;
    logic                      drop_inc;
    logic                      accept;
    logic                      wr_en;
    logic                      wr_err;
    logic [FLIT_WIDTH:0]       rd_data;

    assign in_ready    = ~full;
    assign out_valid   = ~empty;
    assign accept      = in_valid & in_ready;
    assign out_flit    = flit_t'(rd_data[FLIT_WIDTH-1:0]);
    assign out_crc_err = out_valid & rd_data[FLIT_WIDTH] & (out_flit.flit_type == TAIL);
    assign drop_count  = drop_q;

    // Framing FSM, checksum accumulation and drop decision on each accepted flit.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        drop_inc = 1'b0;
        wr_en    = 1'b0;
        wr_err   = 1'b0;
        if (accept) begin
            unique case (in_flit.flit_type)
                HEAD: begin
                    // A HEAD inside a packet means the previous one was truncated.
                    drop_inc = (state_q == ST_PKT);
                    wr_en    = 1'b1;
                    acc_d    = flit_csum(in_flit);
                    state_d  = ST_PKT;
                end
                BODY: begin
                    if (state_q == ST_PKT) begin
                        wr_en = 1'b1;
                        acc_d = acc_q ^ flit_csum(in_flit);
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                TAIL: begin
                    if (state_q == ST_PKT) begin
                        wr_en   = 1'b1;
                        wr_err  = (acc_q != flit_csum(in_flit));
                        state_d = ST_IDLE;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating drop counter.
    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != {CNT_WIDTH{1'b1}})) drop_d = drop_q + CNT_WIDTH'(1);
    end

    // FSM state, checksum accumulator and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            drop_q  <= drop_d;
        end
    end

    flit_rx_queue_sync_fifo #(
        .WIDTH (FLIT_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data ({wr_err, in_flit}),
        .rd_en   (out_ready),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

endmodule
